// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, mode codes and responder state encoding
// for the serial system bus.
package bus_pkg;

    localparam int DATA_WIDTH           = 8;
    localparam int SLAVE_MEM_ADDR_WIDTH = 12;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ADDR   = 3'b001,
        S_WDATA  = 3'b010,
        S_MEM_WR = 3'b011,
        S_MEM_RD = 3'b100,
        S_RDATA  = 3'b101,
        S_SPLIT  = 3'b110
    } state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// serial_shift_rx: N-bit LSB-first deserialiser; done flags the
// cycle the N-th bit is accepted.
module serial_shift_rx #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         bit_i,
    input  logic         valid_i,
    input  logic         clear_i,
    output logic [N-1:0] word_o,
    output logic         done_o
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_q;

    assign done_o = valid_i && (cnt_q == CW'(N - 1));

    // Shifting in at the MSB leaves the first bit at word_o[0].
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            word_o <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (valid_i) begin
            word_o <= {bit_i, word_o[N-1:1]};
            cnt_q  <= done_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/slave_interface.sv
// slave_interface: serial bus responder for one slave memory.
// Define SLAVE_SPLIT_EN to let slow reads release the bus via a split.
module slave_interface #(
    parameter int DATA_WIDTH           = bus_pkg::DATA_WIDTH,
    parameter int SLAVE_MEM_ADDR_WIDTH = bus_pkg::SLAVE_MEM_ADDR_WIDTH,
    parameter int SPLIT_THRESHOLD      = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            ssel,
    input  logic                            swdata,
    input  logic                            swvalid,
    input  logic                            smode,
    output logic                            srdata,
    output logic                            srvalid,
    output logic                            sready,
    output logic                            ssplit,
    input  logic                            split_grant,
    output logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_wen,
    output logic                            mem_ren,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_rvalid
);

    import bus_pkg::*;

    localparam int WW = cnt_width(SLAVE_MEM_ADDR_WIDTH, DATA_WIDTH,
                                  SPLIT_THRESHOLD);

    state_e                st_q;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] rsh_q;
    logic [WW-1:0]         cnt_q;
    logic                  sready_q;
    logic                  srvalid_q;
    logic                  srdata_q;
    logic                  wen_q;
    logic                  ren_q;
    logic                  in_addr;
    logic                  in_wdata;
    logic                  a_vld;
    logic                  a_done;
    logic                  d_vld;
    logic                  d_done;

    assign in_addr  = (st_q == S_IDLE) || (st_q == S_ADDR);
    assign in_wdata = (st_q == S_WDATA);
    assign a_vld    = ssel && swvalid && in_addr;
    assign d_vld    = ssel && swvalid && in_wdata;

    serial_shift_rx #(.N(SLAVE_MEM_ADDR_WIDTH)) u_addr_rx (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .bit_i   (swdata),
        .valid_i (a_vld),
        .clear_i (!(ssel && in_addr)),
        .word_o  (mem_addr),
        .done_o  (a_done)
    );

    serial_shift_rx #(.N(DATA_WIDTH)) u_wdata_rx (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .bit_i   (swdata),
        .valid_i (d_vld),
        .clear_i (!(ssel && in_wdata)),
        .word_o  (mem_wdata),
        .done_o  (d_done)
    );

`ifdef SLAVE_SPLIT_EN
    logic [WW-1:0] wcnt_q;
    logic          ssplit_q;

    assign ssplit = ssplit_q;
`else
    logic unused_grant;

    assign unused_grant = split_grant;
    assign ssplit       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q      <= S_IDLE;
            mode_q    <= MODE_READ;
            rsh_q     <= '0;
            cnt_q     <= '0;
            sready_q  <= 1'b1;
            srvalid_q <= 1'b0;
            srdata_q  <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
`ifdef SLAVE_SPLIT_EN
            wcnt_q    <= '0;
            ssplit_q  <= 1'b0;
`endif
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (ssel && swvalid) begin
                        mode_q   <= smode;
                        sready_q <= 1'b0;
                        st_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!ssel) begin
                        sready_q <= 1'b1;
                        st_q     <= S_IDLE;
                    end else if (a_done) begin
                        if (mode_q == MODE_WRITE) begin
                            st_q <= S_WDATA;
                        end else begin
                            ren_q <= 1'b1;
                            st_q  <= S_MEM_RD;
`ifdef SLAVE_SPLIT_EN
                            wcnt_q <= '0;
`endif
                        end
                    end
                end
                S_WDATA: begin
                    if (!ssel) begin
                        sready_q <= 1'b1;
                        st_q     <= S_IDLE;
                    end else if (d_done) begin
                        wen_q <= 1'b1;
                        st_q  <= S_MEM_WR;
                    end
                end
                S_MEM_WR: begin
                    wen_q    <= 1'b0;
                    sready_q <= 1'b1;
                    st_q     <= S_IDLE;
                end
                S_MEM_RD: begin
                    ren_q <= 1'b0;
                    // A capture on the threshold cycle takes priority.
                    if (mem_rvalid) begin
                        srvalid_q <= 1'b1;
                        srdata_q  <= mem_rdata[0];
                        rsh_q     <= mem_rdata >> 1;
                        cnt_q     <= '0;
                        st_q      <= S_RDATA;
                    end
`ifdef SLAVE_SPLIT_EN
                    else if (wcnt_q == WW'(SPLIT_THRESHOLD)) begin
                        ssplit_q <= 1'b1;
                        st_q     <= S_SPLIT;
                    end else begin
                        wcnt_q <= wcnt_q + WW'(1);
                    end
`endif
                end
                S_RDATA: begin
                    if (cnt_q == WW'(DATA_WIDTH - 1)) begin
                        srvalid_q <= 1'b0;
                        srdata_q  <= 1'b0;
                        cnt_q     <= '0;
                        sready_q  <= 1'b1;
                        st_q      <= S_IDLE;
                    end else begin
                        srdata_q <= rsh_q[0];
                        rsh_q    <= rsh_q >> 1;
                        cnt_q    <= cnt_q + WW'(1);
                    end
                end
`ifdef SLAVE_SPLIT_EN
                S_SPLIT: begin
                    // Hold the word until the arbiter hands the bus back.
                    if (ssplit_q) begin
                        if (mem_rvalid) begin
                            ssplit_q <= 1'b0;
                            rsh_q    <= mem_rdata;
                        end
                    end else if (split_grant) begin
                        srvalid_q <= 1'b1;
                        srdata_q  <= rsh_q[0];
                        rsh_q     <= rsh_q >> 1;
                        cnt_q     <= '0;
                        st_q      <= S_RDATA;
                    end
                end
`endif
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign sready  = sready_q;
    assign srvalid = srvalid_q;
    assign srdata  = srdata_q;
    assign mem_wen = wen_q;
    assign mem_ren = ren_q;

endmodule
